// File: rtl/stopwatch_fnd_if.sv
// ============================================================
// stopwatch_fnd_if: input controls and display/count outputs of stopwatch_fnd.
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

interface stopwatch_fnd_if;
  logic        div_clk;
  logic        btn_run;
  logic        btn_clr;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        running;
  logic [15:0] bcd;
  logic        ovf;

  modport master (
    output div_clk, btn_run, btn_clr,
    input  seg, dp, an, running, bcd, ovf
  );

  modport slave (
    input  div_clk, btn_run, btn_clr,
    output seg, dp, an, running, bcd, ovf
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_fnd.sv
// ============================================================
// stopwatch_fnd: 4-digit BCD stopwatch with scanned common-anode FND driver.
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module stopwatch_fnd #(
  parameter int SCAN_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_fnd_if.slave bus
);

  localparam int                SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_prev;
  logic [2:0]        w_rise;
  logic              w_tick;
  logic              w_run_rise;
  logic              w_clr_rise;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              w_running;
  logic              w_count_en;

  logic [15:0]       r_bcd;
  logic              r_ovf;
  logic [15:0]       w_bcd_inc;
  logic [4:0]        w_carry;

  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_idx;
  logic [3:0]        w_digit;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [3:0]        r_an;

  // Bit order in the synchroniser vectors: {clr, run, div_clk}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_prev  <= 3'b000;
    end else begin
      r_sync1 <= {bus.btn_clr, bus.btn_run, bus.div_clk};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_tick     = w_rise[0];
  assign w_run_rise = w_rise[1];
  assign w_clr_rise = w_rise[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clr_rise) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_run_rise) w_state_next = S_RUN;
        S_RUN:   if (w_run_rise) w_state_next = S_PAUSE;
        S_PAUSE: if (w_run_rise) w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Decodes only the registered state, so nothing here depends on the inputs
  // except the tick qualifier.
  always_comb begin
    w_running  = 1'b0;
    w_count_en = 1'b0;
    case (r_state)
      S_RUN: begin
        w_running  = 1'b1;
        w_count_en = w_tick;
      end
      default: begin
        w_running  = 1'b0;
        w_count_en = 1'b0;
      end
    endcase
  end

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    logic [3:0] w_d;
    assign w_d                   = r_bcd[4*g +: 4];
    assign w_carry[g+1]          = w_carry[g] & (w_d == 4'd9);
    assign w_bcd_inc[4*g +: 4]   = !w_carry[g]  ? w_d  :
                                   (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
  end

  // Clear wins over a same-cycle tick, and suppresses the wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (w_clr_rise) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (w_count_en) begin
      r_bcd <= w_bcd_inc;
      r_ovf <= w_carry[4];
    end else begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      2'd0:    w_digit = r_bcd[3:0];
      2'd1:    w_digit = r_bcd[7:4];
      2'd2:    w_digit = r_bcd[11:8];
      default: w_digit = r_bcd[15:12];
    endcase
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= 4'hF;
    end else begin
      r_seg <= seg_decode(w_digit);
      r_dp  <= (r_idx != 2'd2);
      r_an  <= ~(4'b0001 << r_idx);
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.an      = r_an;
  assign bus.running = w_running;
  assign bus.bcd     = r_bcd;
  assign bus.ovf     = r_ovf;

endmodule

`default_nettype wire
